iob_ethoc_iob2wb: RTL
=====================

IOB_ETHOC_IOB2WB -- requirements
Module: iob_ethoc_iob2wb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width of both buses.
REQ-002 SHALL have parameter DATA_W, default 32, data width of both buses.
REQ-003 SHALL have parameter TIMEOUT_W, default 8, width of the Wishbone wait counter; timeout at 2^TIMEOUT_W-1 cycles.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports: clk_i  in  1  system clock, rising edge.
REQ-005 arst_i  in  1  asynchronous active-high reset.
REQ-006 valid  in  1  IOb native request strobe; a one-cycle pulse is sufficient.
REQ-007 address  in  ADDR_W  byte address of request.
REQ-008 wdata  in  DATA_W  write data.
REQ-009 wstrb  in  DATA_W/8  byte enables; nonzero = write, zero = read.
REQ-010 rdata  out  DATA_W  read data, valid while ready=1.
REQ-011 ready  out  1  one-cycle response pulse.
REQ-012 err  out  1  high with ready when the response is a bus error or timeout.
REQ-013 wb_adr_o  out  ADDR_W, wb_dat_o  out  DATA_W, wb_sel_o  out  DATA_W/8, wb_we_o  out  1, wb_cyc_o  out  1, wb_stb_o  out  1  Wishbone B3 classic initiator outputs toward the MAC register slave.
REQ-014 wb_dat_i  in  DATA_W, wb_ack_i  in  1, wb_err_i  in  1  Wishbone slave responses.

Function
REQ-015 SHALL implement FSM IDLE, BUS, RESP; all outputs registered.
REQ-016 IDLE: on valid=1 at a rising edge, SHALL capture address, wdata, wstrb and enter BUS.
REQ-017 BUS: wb_cyc_o=wb_stb_o=1; wb_adr_o=captured address; wb_dat_o=captured wdata; wb_sel_o = wstrb if write, all ones if read; wb_we_o = |wstrb.
REQ-018 BUS: wb_ack_i=1 -> rdata<=wb_dat_i for reads, 0 for writes; err<=0; enter RESP.
REQ-019 BUS: wb_err_i=1 (priority over ack if both high) -> rdata<=32'hDEADBEEF (lower DATA_W bits), err<=1; enter RESP.
REQ-020 BUS: wait counter increments each cycle; reaching 2^TIMEOUT_W-1 with no ack/err -> drop cyc/stb, treat as error per REQ-019, enter RESP.
REQ-021 Leaving BUS SHALL deassert wb_cyc_o and wb_stb_o in the same edge.
REQ-022 RESP: ready=1 for exactly one cycle, then IDLE; rdata and err SHALL hold until next response.
REQ-023 Minimum latency: valid sampled at edge N, ack in BUS cycle -> ready high after edge N+2.
REQ-024 valid while in BUS or RESP SHALL be ignored (no queuing, no capture change).
REQ-025 ack/err/wb_dat_i outside BUS SHALL be ignored.
REQ-026 Wait counter SHALL clear on entry to BUS.

Reset
REQ-027 arst_i=1 SHALL immediately force IDLE, ready=0, err=0, rdata=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=wb_sel_o=0, counter=0.
REQ-028 Reset asserted during BUS SHALL abort the cycle with no ready pulse; first request after release SHALL be served normally.

Structure
REQ-029 State encodings, error data word 32'hDEADBEEF and default parameter values SHALL live in the shared ethoc defines header.
REQ-030 The wait counter SHALL be a sub-module iob_ethoc_wb_tmr (clear, enable, done output).

Verification
REQ-031 Write MODER: valid pulse, address 0x000, wdata 0x0000A080, wstrb 0xF, slave acks 1 cycle after stb -> wb_we_o=1, wb_sel_o=0xF, ready pulse, err=0, rdata=0.
REQ-032 Read INT_SOURCE: address 0x004, wstrb 0, slave returns 0x00000004 with ack after 3 wait cycles -> wb_sel_o=0xF, ready one cycle, rdata=0x00000004.
REQ-033 Slave asserts wb_err_i and wb_ack_i together on read -> ready with err=1, rdata=0xDEADBEEF.
REQ-034 Slave never acks, TIMEOUT_W=4 -> cyc/stb drop after 15 cycles, ready with err=1, rdata=0xDEADBEEF.
REQ-035 Second valid pulse during BUS -> ignored; only one Wishbone cycle and one ready pulse observed.
REQ-036 arst_i pulsed mid-BUS -> cyc/stb low immediately, no ready; following read of address 0x600 completes with slave data.

Source files
------------

// File: rtl/iob_ethoc_iob2wb_pkg.sv
// rtl/iob_ethoc_iob2wb_pkg.sv - shared ethoc defines: bridge states, error word, default widths
package iob_ethoc_iob2wb_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TIMEOUT_W = 8;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/iob_ethoc_iob2wb_if.sv
// rtl/iob_ethoc_iob2wb_if.sv - IOb native request side plus Wishbone B3 classic initiator side
interface iob_ethoc_iob2wb_if
  import iob_ethoc_iob2wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic                err;

  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_we_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  // master: the bridge itself (IOb target, Wishbone initiator)
  modport master (
    input  valid, address, wdata, wstrb,
    output rdata, ready, err,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  // slave: the surroundings (IOb requester and Wishbone register slave)
  modport slave (
    output valid, address, wdata, wstrb,
    input  rdata, ready, err,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/iob_ethoc_wb_tmr.sv
// rtl/iob_ethoc_wb_tmr.sv - Wishbone wait counter; done flags the last allowed bus cycle
module iob_ethoc_wb_tmr #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clear,
  input  logic enable,
  output logic done
);

  // done while the counter holds 2^W-2, so the bus cycle lasts 2^W-1 clocks
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/iob_ethoc_iob2wb.sv
// rtl/iob_ethoc_iob2wb.sv - IOb native to Wishbone B3 classic bridge with timeout, registered outputs
module iob_ethoc_iob2wb
  import iob_ethoc_iob2wb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  iob_ethoc_iob2wb_if.master         bus
);

  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                tmr_clear, tmr_en, tmr_done;

  iob_ethoc_wb_tmr #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_tmr (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .clear (tmr_clear),
    .enable(tmr_en),
    .done  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready_d   = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          adr_d     = bus.address;
          dat_d     = bus.wdata;
          we_d      = |bus.wstrb;
          sel_d     = (|bus.wstrb) ? bus.wstrb : '1;
          cyc_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        tmr_en = 1'b1;
        // slave error beats ack; timeout only when the slave stays silent
        if (bus.wb_err_i) begin
          rdata_d = ERR_WORD;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = ST_RESP;
        end else if (bus.wb_ack_i) begin
          rdata_d = we_q ? '0 : bus.wb_dat_i;
          err_d   = 1'b0;
          cyc_d   = 1'b0;
          state_d = ST_RESP;
        end else if (tmr_done) begin
          rdata_d = ERR_WORD;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign bus.ready    = ready_q;

endmodule
